// File: rtl/bcd4digit_pkg.sv
// bcd4digit shared constants and types.
// Sequential binary-to-BCD converter, 4 digits.
package bcd4digit_pkg;

  localparam int VALUE_W = 14;
  localparam int QUOT_W  = 10;
  localparam int DIGIT_W = 4;
  localparam int STEPS   = 10;
  localparam int DIGITS  = 4;

  // 10 << 9: divisor for the first quotient bit of a pass
  localparam logic [VALUE_W-1:0] DIV_INIT = 14'd5120;
  localparam logic [VALUE_W-1:0] FOLD     = 14'd10000;

  typedef logic [3:0] step_t;
  typedef logic [1:0] idx_t;

  localparam step_t LAST_STEP = step_t'(STEPS - 1);
  localparam idx_t  LAST_IDX  = idx_t'(DIGITS - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef logic [DIGITS-1:0][DIGIT_W-1:0] digits_t;

endpackage

// File: rtl/bcd4digit_divstep.sv
// bcd4digit restoring-division step.
// Compare and conditional subtract.
module bcd4digit_divstep
  import bcd4digit_pkg::*;
(
  input  logic [VALUE_W-1:0] dividend_i,
  input  logic [VALUE_W-1:0] divisor_i,
  output logic               fit_o,
  output logic [VALUE_W-1:0] rem_o
);

  assign fit_o = (dividend_i >= divisor_i);
  assign rem_o = fit_o ? (dividend_i - divisor_i)
                       : dividend_i;

endmodule

// File: rtl/bcd4digit.sv
// bcd4digit top: FSM, counters, digit shadows.
// One quotient bit per clock, 4 passes of 10.
module bcd4digit
  import bcd4digit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [VALUE_W-1:0] value,
  input  logic               start,
  output logic               ready,
  output logic [DIGIT_W-1:0] A,
  output logic [DIGIT_W-1:0] B,
  output logic [DIGIT_W-1:0] C,
  output logic [DIGIT_W-1:0] D
);

  state_e             state_q, state_d;
  logic [VALUE_W-1:0] dvd_q, dvd_d;
  logic [VALUE_W-1:0] dvs_q, dvs_d;
  logic [QUOT_W-1:0]  quo_q, quo_d;
  logic [QUOT_W-1:0]  quo_nx;
  step_t              step_q, step_d;
  step_t              bit_pos;
  idx_t               idx_q, idx_d;
  digits_t            sh_q, sh_d;
  digits_t            out_q, out_d;
  logic               rdy_q, rdy_d;
  logic               fit;
  logic [VALUE_W-1:0] rem;

  bcd4digit_divstep u_step (
    .dividend_i (dvd_q),
    .divisor_i  (dvs_q),
    .fit_o      (fit),
    .rem_o      (rem)
  );

  assign bit_pos = LAST_STEP - step_q;

  // next state: accept, step, end of pass, completion
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    quo_d   = quo_q;
    step_d  = step_q;
    idx_d   = idx_q;
    sh_d    = sh_q;
    out_d   = out_q;
    rdy_d   = rdy_q;
    quo_nx  = quo_q;
    quo_nx[bit_pos] = fit;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          // folding off 10000 keeps the first quotient
          // within 10 bits; that digit is dropped anyway
          dvd_d   = (value >= FOLD) ? (value - FOLD)
                                    : value;
          dvs_d   = DIV_INIT;
          quo_d   = '0;
          step_d  = '0;
          idx_d   = '0;
          rdy_d   = 1'b0;
        end
      end
      RUN: begin
        dvd_d  = rem;
        dvs_d  = dvs_q >> 1;
        quo_d  = quo_nx;
        step_d = step_q + 1'b1;
        if (step_q == LAST_STEP) begin
          sh_d[idx_q] = rem[DIGIT_W-1:0];
          dvd_d  = VALUE_W'(quo_nx);
          dvs_d  = DIV_INIT;
          quo_d  = '0;
          step_d = '0;
          idx_d  = idx_q + 1'b1;
          if (idx_q == LAST_IDX) begin
            out_d   = sh_d;
            rdy_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state register with asynchronous clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      quo_q   <= '0;
      step_q  <= '0;
      idx_q   <= '0;
      sh_q    <= '0;
      out_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      quo_q   <= quo_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      out_q   <= out_d;
      rdy_q   <= rdy_d;
    end
  end

  assign ready = rdy_q;
  assign A     = out_q[3];
  assign B     = out_q[2];
  assign C     = out_q[1];
  assign D     = out_q[0];

endmodule

// File: tb/tb_bcd4digit.sv
// bcd4digit bench: behavioural model plus
// per-cycle compare and directed literals.
module tb_bcd4digit;

  logic        clk;
  logic        rst;
  logic [13:0] value;
  logic        start;
  logic        ready;
  logic [3:0]  A, B, C, D;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 0;

  bcd4digit dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .start (start),
    .ready (ready),
    .A     (A),
    .B     (B),
    .C     (C),
    .D     (D)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] digits(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               nm, got, exp);
    end
  endtask

  // model: conversion takes 40 edges after accept
  bit          m_busy = 0;
  int          m_cnt  = 0;
  int          m_val  = 0;
  bit          m_rdy  = 0;
  logic [15:0] m_dig  = '0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy <= 0;
      m_cnt  <= 0;
      m_rdy  <= 0;
      m_dig  <= '0;
    end else if (m_busy) begin
      m_cnt <= m_cnt + 1;
      if (m_cnt == 39) begin
        m_busy <= 0;
        m_rdy  <= 1;
        m_dig  <= digits(m_val);
      end
    end else if (start) begin
      m_busy <= 1;
      m_cnt  <= 0;
      m_val  <= int'(value);
      m_rdy  <= 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en && rst) begin
      chk("cyc_ready", 32'(ready), 32'(m_rdy));
      chk("cyc_digits", 32'({A, B, C, D}), 32'(m_dig));
    end
  end

  task automatic conv(input int v,
                      input logic [15:0] exp,
                      input string nm);
    int k;
    value = 14'(v);
    start = 1;
    @(negedge clk);
    start = 0;
    k = 0;
    while (!ready && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_lat"}, 32'(k), 32'd40);
    chk({nm, "_dig"}, 32'({A, B, C, D}), 32'(exp));
  endtask

  initial begin
    int k;
    int r[3];
    int nr;
    bit prev;
    rst   = 1;
    value = 14'd4934;
    start = 0;
    #1 rst = 0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_digits", 32'({A, B, C, D}), 32'd0);
    chk("model_pin16383", 32'(digits(16383)),
        32'h6383);
    chk("model_pin9999", 32'(digits(9999)), 32'h9999);
    chk_en = 1;
    rst = 1;
    conv(4934, 16'h4934, "v4934");
    repeat (3) @(negedge clk);
    chk("ready_hold", 32'(ready), 32'd1);
    conv(0, 16'h0000, "v0");
    conv(9999, 16'h9999, "v9999");
    conv(10, 16'h0010, "v10");
    conv(16383, 16'h6383, "v16383");
    conv(10000, 16'h0000, "v10000");

    // start during a run is ignored
    value = 14'd1234;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (19) @(negedge clk);
    value = 14'd5678;
    start = 1;
    @(negedge clk);
    start = 0;
    value = 14'd0;
    k = 20;
    while (!ready && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("ign_lat", 32'(k), 32'd40);
    chk("ign_dig", 32'({A, B, C, D}), 32'h1234);

    // reset partway through a conversion
    value = 14'd7777;
    start = 1;
    @(negedge clk);
    start = 0;
    repeat (24) @(negedge clk);
    #2 rst = 0;
    #1;
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_dig", 32'({A, B, C, D}), 32'd0);
    @(negedge clk);
    rst = 1;
    conv(42, 16'h0042, "v42");

    // start held high: periodic retrigger
    nr = 0;
    prev = ready;
    k = 0;
    start = 1;
    while (nr < 3 && k < 200) begin
      value = 14'($urandom_range(0, 16383));
      @(negedge clk);
      k++;
      if (ready && !prev) begin
        r[nr] = k;
        nr++;
      end
      prev = ready;
    end
    start = 0;
    chk("retrig_pulses", 32'(nr), 32'd3);
    if (nr == 3) begin
      chk("retrig_per1", 32'(r[1] - r[0]), 32'd41);
      chk("retrig_per2", 32'(r[2] - r[1]), 32'd41);
    end
    @(negedge clk);

    // randomized values with idle gaps
    for (int i = 0; i < 20; i++) begin
      int v;
      v = int'($urandom_range(0, 16383));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      conv(v, digits(v), "rand");
    end

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
